drive_cmd_uart_tx: RTL and testbench

- Consumes the 3-bit drive command and the state-change pulse produced by the mode/drive FSM.
- Converts the command into signed left/right wheel velocities.
- Serialises them as a 5-byte Drive Direct packet (opcode 145) over 8N1 UART to the robot base.
- Sends on every command change, on an FSM state-change pulse, and on a periodic keep-alive refresh.

---
 rtl/drive_cmd_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_drive_cmd_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/drive_cmd_uart_tx.sv
// rtl/drive_cmd_uart_tx.sv - Drive command to Drive Direct (opcode 145) packet over 8N1 UART
module drive_cmd_uart_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int SLOW_MMS   = 100,
    parameter int MED_MMS    = 200,
    parameter int FAST_MMS   = 300,
    parameter int TURN_MMS   = 100,
    parameter int REFRESH_MS = 100
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [2:0] drive_state,
    input  logic       state_change,
    output logic       tx,
    output logic       busy,
    output logic       pkt_sent
);

    localparam int BAUD_DIV       = CLK_HZ / BAUD;
    localparam int REFRESH_CYCLES = CLK_HZ / 1000 * REFRESH_MS;
    localparam int BW             = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int RW             = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LAST    = BW'(BAUD_DIV - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [7:0]    OPCODE       = 8'h91;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t     state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n, bit_next;
    logic [2:0]    byte_idx, byte_n;
    logic [RW-1:0] refresh_cnt, refresh_n;
    logic [2:0]    last_sent, last_n;
    logic          pending_force, force_n;
    logic          tx_r, tx_n, busy_r, busy_n, sent_r, sent_n;
    logic          load, trigger, baud_done;
    logic [7:0]    pkt_buf [5];
    logic [7:0]    cur_byte;
    logic [31:0]   vel;

    // Returns {right, left} wheel velocity, signed 16-bit each.
    function automatic logic [31:0] wheel_vel(input logic [2:0] cmd);
        logic [15:0] turn, r, l;
        turn = 16'(TURN_MMS);
        case (cmd)
            3'b001:  begin r = turn;            l = -turn;           end
            3'b010:  begin r = -turn;           l = turn;            end
            3'b011:  begin r = 16'(SLOW_MMS);   l = 16'(SLOW_MMS);   end
            3'b100:  begin r = 16'(MED_MMS);    l = 16'(MED_MMS);    end
            3'b101:  begin r = 16'(FAST_MMS);   l = 16'(FAST_MMS);   end
            default: begin r = 16'd0;           l = 16'd0;           end
        endcase
        return {r, l};
    endfunction

    assign vel       = wheel_vel(drive_state);
    assign cur_byte  = pkt_buf[byte_idx];
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign bit_next  = bit_cnt + 3'd1;
    assign trigger   = (drive_state != last_sent) || pending_force || (refresh_cnt == REFRESH_LAST);

    always_comb begin
        state_n   = state;
        baud_n    = baud_cnt;
        bit_n     = bit_cnt;
        byte_n    = byte_idx;
        refresh_n = refresh_cnt;
        last_n    = last_sent;
        force_n   = pending_force | state_change;
        tx_n      = tx_r;
        busy_n    = busy_r;
        sent_n    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (trigger) begin
                    // A coincident state_change is absorbed by this launch.
                    load      = 1'b1;
                    last_n    = drive_state;
                    force_n   = 1'b0;
                    refresh_n = '0;
                    baud_n    = '0;
                    byte_n    = 3'd0;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                    state_n   = START;
                end else begin
                    refresh_n = refresh_cnt + 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    tx_n    = cur_byte[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_next;
                        tx_n  = cur_byte[bit_next];
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (byte_idx < 3'd4) begin
                        byte_n  = byte_idx + 3'd1;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        sent_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= 3'd0;
            byte_idx      <= 3'd0;
            refresh_cnt   <= '0;
            last_sent     <= 3'b111;
            pending_force <= 1'b0;
            tx_r          <= 1'b1;
            busy_r        <= 1'b0;
            sent_r        <= 1'b0;
        end else begin
            state         <= state_n;
            baud_cnt      <= baud_n;
            bit_cnt       <= bit_n;
            byte_idx      <= byte_n;
            refresh_cnt   <= refresh_n;
            last_sent     <= last_n;
            pending_force <= force_n;
            tx_r          <= tx_n;
            busy_r        <= busy_n;
            sent_r        <= sent_n;
        end
    end

    // Bytes are frozen at launch so mid-packet command changes cannot corrupt them.
    always_ff @(posedge clk_50) begin
        if (load) begin
            pkt_buf[0] <= OPCODE;
            pkt_buf[1] <= vel[31:24];
            pkt_buf[2] <= vel[23:16];
            pkt_buf[3] <= vel[15:8];
            pkt_buf[4] <= vel[7:0];
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign pkt_sent = sent_r;

endmodule

// File: tb/tb_drive_cmd_uart_tx.sv
// tb/tb_drive_cmd_uart_tx.sv - Scoreboard bench for drive_cmd_uart_tx
module tb_drive_cmd_uart_tx;

    localparam int PKT_CYC     = 500;
    localparam int REFRESH_CYC = 1000;

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] drive_state = 3'b000;
    logic       state_change = 1'b0;
    logic       tx, busy, pkt_sent;

    drive_cmd_uart_tx #(
        .CLK_HZ(1000), .BAUD(100), .REFRESH_MS(1000)
    ) dut (
        .clk_50(clk_50), .reset_n(reset_n), .drive_state(drive_state),
        .state_change(state_change), .tx(tx), .busy(busy), .pkt_sent(pkt_sent)
    );

    always #5 clk_50 = ~clk_50;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk_50) begin
        cyc   <= cyc + 1;
        rst_q <= reset_n;
    end

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    int          pkts_done = 0;
    int          fall_at [64];
    int          sent_at [64];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Monitor: decodes tx, checks bit timing and framing, compares against the scoreboard.
    logic [39:0] got_pkt;
    int          bad_hold, bad_frame, bad_busy, frame, pos, phase;
    logic        held, aborted;
    initial begin : monitor
        forever begin
            @(negedge clk_50);
            if (rst_q && tx === 1'b0) begin
                got_pkt = '0; bad_hold = 0; bad_frame = 0; bad_busy = 0;
                aborted = 1'b0; held = 1'b0;
                fall_at[pkts_done] = cyc;
                for (int k = 0; k < PKT_CYC; k++) begin
                    if (k > 0) @(negedge clk_50);
                    if (!rst_q) begin
                        aborted = 1'b1;
                        break;
                    end
                    frame = k / 100;
                    pos   = (k % 100) / 10;
                    phase = k % 10;
                    if (phase == 0) held = tx;
                    else if (tx !== held) bad_hold++;
                    if (pos == 0 && tx !== 1'b0) bad_frame++;
                    if (pos == 9 && tx !== 1'b1) bad_frame++;
                    if (pos >= 1 && pos <= 8 && phase == 0) got_pkt[32 - 8*frame + pos - 1] = tx;
                    if (busy !== 1'b1 || pkt_sent !== 1'b0) bad_busy++;
                end
                if (!aborted) begin
                    @(negedge clk_50);
                    if (!rst_q) aborted = 1'b1;
                end
                if (aborted) begin
                    check("abort_tx_high", 64'(tx), 64'(1));
                    check("abort_busy_low", 64'(busy), 64'(0));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    sent_at[pkts_done] = cyc;
                    check("pkt_sent_at_500", 64'(pkt_sent), 64'(1));
                    check("busy_low_at_end", 64'(busy), 64'(0));
                    check("bit_hold_10", 64'(bad_hold), 64'(0));
                    check("start_stop_bits", 64'(bad_frame), 64'(0));
                    check("busy_in_flight", 64'(bad_busy), 64'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_packet: got %0h, required none", got_pkt);
                    end else begin
                        check("packet_bytes", 64'(got_pkt), 64'(exp_q.pop_front()));
                    end
                    pkts_done++;
                end
            end
        end
    end

    task automatic wait_pkts(input int n, input int limit);
        int t = 0;
        while (pkts_done < n && t < limit) begin
            @(negedge clk_50);
            t++;
        end
        check("packet_arrived", 64'(pkts_done >= n), 64'(1));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_50);
    endtask

    int rel, base;
    initial begin : stimulus
        cycles(4);
        check("reset_tx", 64'(tx), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_pkt_sent", 64'(pkt_sent), 64'(0));

        // Reset release sends the current command (STOP)
        exp_q.push_back(40'h91_0000_0000);
        reset_n = 1'b1;
        rel = cyc;
        wait_pkts(1, 700);
        check("release_latency", 64'(fall_at[0] - rel), 64'(1));

        // SLOW then LEFT
        drive_state = 3'b011;
        exp_q.push_back(40'h91_0064_0064);
        wait_pkts(2, 700);
        drive_state = 3'b001;
        exp_q.push_back(40'h91_0064_FF9C);
        wait_pkts(3, 700);

        // FAST held: one change packet then two keep-alive refreshes
        drive_state = 3'b101;
        exp_q.push_back(40'h91_012C_012C);
        exp_q.push_back(40'h91_012C_012C);
        exp_q.push_back(40'h91_012C_012C);
        wait_pkts(4, 700);
        wait_pkts(5, 2000);
        check("refresh_gap_1", 64'(fall_at[4] - sent_at[3]), 64'(REFRESH_CYC));
        wait_pkts(6, 2000);
        check("refresh_gap_2", 64'(fall_at[5] - sent_at[4]), 64'(REFRESH_CYC));

        // Command change during byte 2 of a STOP packet
        drive_state = 3'b000;
        exp_q.push_back(40'h91_0000_0000);
        exp_q.push_back(40'h91_FF9C_0064);
        cycles(151);
        drive_state = 3'b010;
        wait_pkts(8, 1400);
        check("back_to_back_gap", 64'(fall_at[7] - sent_at[6]), 64'(1));

        // MEDIUM, forced resend, then pulse coincident with a change
        drive_state = 3'b100;
        exp_q.push_back(40'h91_00C8_00C8);
        wait_pkts(9, 700);
        state_change = 1'b1;
        exp_q.push_back(40'h91_00C8_00C8);
        @(negedge clk_50);
        state_change = 1'b0;
        wait_pkts(10, 700);
        drive_state  = 3'b011;
        state_change = 1'b1;
        exp_q.push_back(40'h91_0064_0064);
        @(negedge clk_50);
        state_change = 1'b0;
        wait_pkts(11, 700);
        base = pkts_done;
        cycles(900);
        check("coincident_single_packet", 64'(pkts_done), 64'(base));

        // Reset mid byte 3 aborts; fresh packet follows release
        drive_state = 3'b010;
        exp_q.push_back(40'h91_FF9C_0064);
        cycles(251);
        reset_n = 1'b0;
        exp_q.push_back(40'h91_FF9C_0064);
        cycles(3);
        reset_n = 1'b1;
        rel = cyc;
        wait_pkts(12, 700);
        check("post_reset_latency", 64'(fall_at[11] - rel), 64'(1));

        // Code 111 encodes as STOP
        drive_state = 3'b111;
        exp_q.push_back(40'h91_0000_0000);
        wait_pkts(13, 700);
        cycles(20);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("total_packets", 64'(pkts_done), 64'(13));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
